// File: rtl/afm_top.sv
// AFM board top: 6-LED bouncing scanner, used as the bring-up heartbeat.
// Ports: xtal clock in, sync active-high reset in, 6-bit LED drive out.
module afm_top #(
  parameter int unsigned TICK_DIV       = 2_700_000,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic       bank1_3v3_xtal_in,
  input  logic       bank3_1v8_sys_rst,
  output logic [5:0] bank3_1v8_led
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [5:0] LED_RST =
    LED_ACTIVE_LOW ? 6'b111110 : 6'b000001;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  logic [PW-1:0] presc_q;
  logic [2:0]    pos_q;
  logic [2:0]    pos_nxt;
  dir_e          dir_q;
  dir_e          dir_nxt;
  logic [5:0]    led_q;
  logic [5:0]    led_nxt;
  logic [5:0]    onehot;
  logic          tick;

  assign tick = (presc_q == PRESC_MAX);

  // Endpoints turn around immediately so 0 and 5 each
  // dwell for exactly one step.
  always_comb begin
    pos_nxt = pos_q;
    dir_nxt = dir_q;
    unique case (1'b1)
      (dir_q == UP) && (pos_q < 3'd5): begin
        pos_nxt = pos_q + 3'd1;
      end
      (dir_q == UP) && (pos_q >= 3'd5): begin
        pos_nxt = 3'd4;
        dir_nxt = DOWN;
      end
      (dir_q == DOWN) && (pos_q > 3'd0): begin
        pos_nxt = pos_q - 3'd1;
      end
      (dir_q == DOWN) && (pos_q == 3'd0): begin
        pos_nxt = 3'd1;
        dir_nxt = UP;
      end
      default: begin
        pos_nxt = 3'd0;
        dir_nxt = UP;
      end
    endcase
  end

  always_comb begin
    onehot  = 6'd1 << pos_nxt;
    led_nxt = LED_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge bank1_3v3_xtal_in) begin
    if (bank3_1v8_sys_rst) begin
      presc_q <= '0;
      pos_q   <= 3'd0;
      dir_q   <= UP;
      led_q   <= LED_RST;
    end else if (tick) begin
      presc_q <= '0;
      pos_q   <= pos_nxt;
      dir_q   <= dir_nxt;
      led_q   <= led_nxt;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign bank3_1v8_led = led_q;

endmodule

// File: tb/tb_afm_top.sv
// Bench for afm_top: directed walk, mid-scan reset,
// active-high variant and random reset pulses.
module tb_afm_top;

  logic       clk;
  logic       rst;
  logic [5:0] led_lo;
  logic [5:0] led_hi;

  int errs;
  int nchk;

  afm_top #(
    .TICK_DIV      (4),
    .LED_ACTIVE_LOW(1'b1)
  ) u_lo (
    .bank1_3v3_xtal_in(clk),
    .bank3_1v8_sys_rst(rst),
    .bank3_1v8_led    (led_lo)
  );

  afm_top #(
    .TICK_DIV      (4),
    .LED_ACTIVE_LOW(1'b0)
  ) u_hi (
    .bank1_3v3_xtal_in(clk),
    .bank3_1v8_sys_rst(rst),
    .bank3_1v8_led    (led_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [5:0] got,
    input logic [5:0] exp
  );
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scanner position for step index i (period 10).
  function automatic int seq_pos(input int i);
    int m;
    m = i % 10;
    return (m <= 5) ? m : 10 - m;
  endfunction

  function automatic logic [5:0] oh(input int p);
    logic [5:0] v;
    v = 6'd1 << p;
    return v;
  endfunction

  int mpresc;
  int mpos;
  bit mdir;
  int ones;

  initial begin
    errs = 0;
    nchk = 0;
    rst  = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_lo", led_lo, 6'b111110);
      chk("rst_hi", led_hi, 6'b000001);
    end

    // Edge n after release shows step n/4.
    rst = 1'b0;
    for (int n = 1; n <= 52; n++) begin
      step();
      chk("walk_lo", led_lo, ~oh(seq_pos(n / 4)));
      chk("walk_hi", led_hi, oh(seq_pos(n / 4)));
    end
    chk("pre_mid", led_lo, 6'b110111);

    rst = 1'b1;
    step();
    chk("mid_rst", led_lo, 6'b111110);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_hold", led_lo, 6'b111110);
    end
    step();
    chk("mid_step", led_lo, 6'b111101);

    // Random reset pulses against a reference model.
    rst = 1'b1;
    mpresc = 0;
    mpos   = 0;
    mdir   = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (rst) begin
        mpresc = 0;
        mpos   = 0;
        mdir   = 1'b0;
      end else if (mpresc == 3) begin
        mpresc = 0;
        if (!mdir) begin
          if (mpos == 5) begin
            mpos = 4;
            mdir = 1'b1;
          end else begin
            mpos++;
          end
        end else begin
          if (mpos == 0) begin
            mpos = 1;
            mdir = 1'b0;
          end else begin
            mpos--;
          end
        end
      end else begin
        mpresc++;
      end
      chk("rnd_lo", led_lo, ~oh(mpos));
      chk("rnd_hi", led_hi, oh(mpos));
      ones = $countones(~led_lo);
      chk("rnd_one", 6'(ones), 6'd1);
      rst = ($urandom_range(0, 11) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
